// File: rtl/id_pkg.sv
// Shared decode/issue definitions: serializer states, default drain depth,
// and the decoded-bundle field layout agreed between decode and EXE.
package id_pkg;

  typedef enum logic [1:0] {
    ID_SER_IDLE   = 2'd0,
    ID_SER_DRAIN  = 2'd1,
    ID_SER_NOTIFY = 2'd2
  } id_ser_state_e;

  localparam int ID_DRAIN_DEPTH_DEF = 3;

  // Bundle layout (LSB offsets, 32-bit fields) in the 160-bit payload
  localparam int ID_F_INSTR = 0;
  localparam int ID_F_PC    = 32;
  localparam int ID_F_OPA   = 64;
  localparam int ID_F_OPB   = 96;
  localparam int ID_F_CTRL  = 128;
  localparam int ID_F_W     = 32;

endpackage

// File: rtl/id_drain_counter.sv
// Loadable down-counter for the serialization drain; term flags the last
// bubble (cnt==1). Everything holds while en (I-cache hit) is low.
module id_drain_counter #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  always_ff @(posedge CLK) begin
    if (RESET)
      cnt <= '0;
    else if (en) begin
      if (load)
        cnt <= load_val;
      else if (dec)
        cnt <= cnt - CNT_W'(1);
    end
  end

  assign term = (cnt == CNT_W'(1));

endmodule

// File: rtl/id_serialize_stage.sv
// Decode-to-EXE issue register. Serializing instructions issue a marker,
// drain DRAIN_DEPTH bubbles, then spend one NOTIFY cycle (optional SYS pulse).
module id_serialize_stage
  import id_pkg::*;
#(
  parameter int DATA_W      = 160,
  parameter int DRAIN_DEPTH = ID_DRAIN_DEPTH_DEF,
  parameter int CNT_W       = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              hit,
  input  logic              in_valid,
  input  logic              in_serial,
  input  logic              in_notify,
  input  logic [DATA_W-1:0] in_payload,
  input  logic              in_redirect,
  input  logic [31:0]       in_redirect_pc,
  output logic              out_valid,
  output logic              out_serial,
  output logic [DATA_W-1:0] out_payload,
  output logic [31:0]       Alt_PC,
  output logic              Request_Alt_PC,
  output logic              SYS,
  output logic              WANT_FREEZE
);

  id_ser_state_e     state, state_nxt;
  logic              notify_q, notify_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_term, cnt_load, cnt_dec;
  logic              vld_nxt, ser_nxt, req_nxt, sys_nxt;
  logic [DATA_W-1:0] pay_nxt;
  logic [31:0]       alt_nxt;

  id_drain_counter #(.CNT_W(CNT_W)) u_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .en       (hit),
    .load     (cnt_load),
    .load_val (CNT_W'(DRAIN_DEPTH)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .term     (cnt_term)
  );

  always_comb begin
    state_nxt  = state;
    notify_nxt = notify_q;
    vld_nxt    = 1'b0;
    ser_nxt    = 1'b0;
    pay_nxt    = '0;
    req_nxt    = 1'b0;
    alt_nxt    = Alt_PC;
    sys_nxt    = SYS;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      ID_SER_IDLE: begin
        if (in_valid && in_serial) begin
          // Marker slot: no payload, redirect ignored
          vld_nxt    = 1'b1;
          ser_nxt    = 1'b1;
          cnt_load   = 1'b1;
          notify_nxt = in_notify;
          state_nxt  = ID_SER_DRAIN;
        end else if (in_valid) begin
          vld_nxt = 1'b1;
          pay_nxt = in_payload;
          req_nxt = in_redirect;
          alt_nxt = in_redirect_pc;
        end
      end
      ID_SER_DRAIN: begin
        cnt_dec = 1'b1;
        if (cnt_term) begin
          state_nxt = ID_SER_NOTIFY;
          sys_nxt   = notify_q;
        end
      end
      ID_SER_NOTIFY: begin
        sys_nxt   = 1'b0;
        state_nxt = ID_SER_IDLE;
      end
      default: state_nxt = ID_SER_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= ID_SER_IDLE;
      notify_q       <= 1'b0;
      out_valid      <= 1'b0;
      out_serial     <= 1'b0;
      out_payload    <= '0;
      Alt_PC         <= '0;
      Request_Alt_PC <= 1'b0;
      SYS            <= 1'b0;
    end else if (hit) begin
      state          <= state_nxt;
      notify_q       <= notify_nxt;
      out_valid      <= vld_nxt;
      out_serial     <= ser_nxt;
      out_payload    <= pay_nxt;
      Alt_PC         <= alt_nxt;
      Request_Alt_PC <= req_nxt;
      SYS            <= sys_nxt;
    end
  end

  // Fetch may advance past a serializing instruction only during NOTIFY
  assign WANT_FREEZE = !hit || (in_valid && in_serial && state != ID_SER_NOTIFY);

endmodule

// File: tb/tb_id_serialize_stage.sv
// Directed bench for id_serialize_stage: DRAIN_DEPTH=3 instance for most
// scenarios, a DRAIN_DEPTH=1 instance for back-to-back serial sequences.
module tb_id_serialize_stage;
  import id_pkg::*;

  localparam int DW = 160;

  logic          CLK = 1'b0;
  logic          RESET, hit, in_valid, in_serial, in_notify, in_redirect;
  logic [DW-1:0] in_payload;
  logic [31:0]   in_redirect_pc;

  logic          v3, s3, req3, sys3, wf3;
  logic [DW-1:0] pay3;
  logic [31:0]   alt3;
  logic          v1, s1, req1, sys1, wf1;
  logic [DW-1:0] pay1;
  logic [31:0]   alt1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  localparam logic [DW-1:0] P_A = {5{32'hA0A0_0001}};
  localparam logic [DW-1:0] P_B = {5{32'hB0B0_0002}};
  localparam logic [DW-1:0] P_C = {5{32'hC0C0_0003}};
  localparam logic [DW-1:0] P_D = {5{32'hD0D0_0004}};
  localparam logic [DW-1:0] P_S = {5{32'h5555_000C}};
  localparam logic [DW-1:0] P_N = {5{32'h7777_0009}};

  always #5 CLK = ~CLK;

  id_serialize_stage #(.DATA_W(DW), .DRAIN_DEPTH(3), .CNT_W(4)) dut3 (
    .CLK(CLK), .RESET(RESET), .hit(hit), .in_valid(in_valid), .in_serial(in_serial),
    .in_notify(in_notify), .in_payload(in_payload), .in_redirect(in_redirect),
    .in_redirect_pc(in_redirect_pc), .out_valid(v3), .out_serial(s3), .out_payload(pay3),
    .Alt_PC(alt3), .Request_Alt_PC(req3), .SYS(sys3), .WANT_FREEZE(wf3));

  id_serialize_stage #(.DATA_W(DW), .DRAIN_DEPTH(1), .CNT_W(4)) dut1 (
    .CLK(CLK), .RESET(RESET), .hit(hit), .in_valid(in_valid), .in_serial(in_serial),
    .in_notify(in_notify), .in_payload(in_payload), .in_redirect(in_redirect),
    .in_redirect_pc(in_redirect_pc), .out_valid(v1), .out_serial(s1), .out_payload(pay1),
    .Alt_PC(alt1), .Request_Alt_PC(req1), .SYS(sys1), .WANT_FREEZE(wf1));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_serial = 0; in_notify = 0; in_redirect = 0;
    in_redirect_pc = '0; in_payload = '0;
  endtask

  task automatic test_reset();
    RESET = 1; hit = 1; idle_inputs();
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {v3, s3, sys3, req3});
    else pass_cnt++;
    tot_cnt++;
    if (pay3 !== '0 || alt3 !== 32'h0) $display("FAIL reset_data: got pay=%h alt=%h want 0", pay3, alt3);
    else pass_cnt++;
    tot_cnt++;
    if (wf3 !== 1'b0) $display("FAIL reset_freeze: got %b want 0", wf3);
    else pass_cnt++;
    RESET = 0;
  endtask

  task automatic test_stream();
    in_valid = 1; in_payload = P_A; in_redirect = 0; in_redirect_pc = 32'h0;
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b1000 || pay3 !== P_A) $display("FAIL stream_A: got flags=%b pay=%h want 1000 %h", {v3, s3, sys3, req3}, pay3, P_A);
    else pass_cnt++;
    in_payload = P_B; in_redirect = 1; in_redirect_pc = 32'h400;
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b1001 || pay3 !== P_B || alt3 !== 32'h400) $display("FAIL stream_B: got flags=%b alt=%h want 1001 400", {v3, s3, sys3, req3}, alt3);
    else pass_cnt++;
    in_payload = P_C; in_redirect = 0; in_redirect_pc = 32'h0;
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b1000 || pay3 !== P_C || alt3 !== 32'h0) $display("FAIL stream_C: got flags=%b alt=%h want 1000 0", {v3, s3, sys3, req3}, alt3);
    else pass_cnt++;
    // Miss while streaming: D must not be captured
    hit = 0; in_payload = P_D; in_redirect = 1; in_redirect_pc = 32'h888;
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b1000 || pay3 !== P_C || alt3 !== 32'h0 || wf3 !== 1'b1) $display("FAIL stream_miss_hold: got flags=%b alt=%h wf=%b want 1000 0 1", {v3, s3, sys3, req3}, alt3, wf3);
    else pass_cnt++;
    hit = 1; idle_inputs();
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b0000 || pay3 !== '0) $display("FAIL stream_empty: got flags=%b want 0000", {v3, s3, sys3, req3});
    else pass_cnt++;
  endtask

  task automatic test_syscall(input logic notify, input string nm);
    logic exp_sys;
    logic exp_wf;
    in_valid = 1; in_serial = 1; in_notify = notify; in_payload = P_S;
    in_redirect = 1; in_redirect_pc = 32'h123;
    #1;
    tot_cnt++;
    if (wf3 !== 1'b1) $display("FAIL %s_freeze_pre: got %b want 1", nm, wf3);
    else pass_cnt++;
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b1100 || pay3 !== '0 || wf3 !== 1'b1) $display("FAIL %s_marker: got flags=%b wf=%b want 1100 1", nm, {v3, s3, sys3, req3}, wf3);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_sys = (i == 2) ? notify : 1'b0;
      exp_wf  = (i == 2) ? 1'b0 : 1'b1;
      tot_cnt++;
      if ({v3, s3, sys3, req3} !== {2'b00, exp_sys, 1'b0} || pay3 !== '0 || wf3 !== exp_wf) $display("FAIL %s_bubble%0d: got flags=%b wf=%b want %b %b", nm, i, {v3, s3, sys3, req3}, wf3, {2'b00, exp_sys, 1'b0}, exp_wf);
      else pass_cnt++;
    end
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b0000) $display("FAIL %s_notify_exit: got flags=%b want 0000", nm, {v3, s3, sys3, req3});
    else pass_cnt++;
    in_serial = 0; in_redirect = 0; in_redirect_pc = 32'h0; in_payload = P_N;
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b1000 || pay3 !== P_N) $display("FAIL %s_next_issue: got flags=%b pay=%h want 1000 %h", nm, {v3, s3, sys3, req3}, pay3, P_N);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_miss();
    in_valid = 1; in_serial = 1; in_notify = 1; in_payload = P_S;
    step();
    step();
    hit = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      tot_cnt++;
      if (dut3.u_cnt.cnt !== 4'd2 || dut3.state !== ID_SER_DRAIN || wf3 !== 1'b1 || {v3, s3, sys3, req3} !== 4'b0000)
        $display("FAIL miss_drain%0d: got cnt=%0d st=%0d wf=%b flags=%b want 2 1 1 0000", i, dut3.u_cnt.cnt, dut3.state, wf3, {v3, s3, sys3, req3});
      else pass_cnt++;
    end
    hit = 1;
    step();
    tot_cnt++;
    if (dut3.u_cnt.cnt !== 4'd1 || {v3, s3, sys3, req3} !== 4'b0000) $display("FAIL miss_resume: got cnt=%0d flags=%b want 1 0000", dut3.u_cnt.cnt, {v3, s3, sys3, req3});
    else pass_cnt++;
    step();
    tot_cnt++;
    if (sys3 !== 1'b1 || dut3.state !== ID_SER_NOTIFY) $display("FAIL miss_sys_rise: got sys=%b st=%0d want 1 2", sys3, dut3.state);
    else pass_cnt++;
    hit = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      tot_cnt++;
      if (sys3 !== 1'b1 || dut3.state !== ID_SER_NOTIFY || wf3 !== 1'b1) $display("FAIL miss_sys_hold%0d: got sys=%b st=%0d wf=%b want 1 2 1", i, sys3, dut3.state, wf3);
      else pass_cnt++;
    end
    hit = 1;
    step();
    tot_cnt++;
    if (sys3 !== 1'b0 || dut3.state !== ID_SER_IDLE || v3 !== 1'b0) $display("FAIL miss_sys_fall: got sys=%b st=%0d v=%b want 0 0 0", sys3, dut3.state, v3);
    else pass_cnt++;
    in_serial = 0; in_notify = 0; in_payload = P_N;
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b1000 || pay3 !== P_N) $display("FAIL miss_next_issue: got flags=%b want 1000", {v3, s3, sys3, req3});
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    in_valid = 1; in_serial = 1; in_notify = 1; in_payload = P_S;
    step();
    step();
    RESET = 1;
    step();
    tot_cnt++;
    if ({v3, s3, sys3, req3} !== 4'b0000 || pay3 !== '0 || alt3 !== 32'h0 || dut3.state !== ID_SER_IDLE)
      $display("FAIL rst_mid_clear: got flags=%b st=%0d want 0000 0", {v3, s3, sys3, req3}, dut3.state);
    else pass_cnt++;
    RESET = 0; idle_inputs();
    for (int i = 0; i < 6; i++) begin
      step();
      tot_cnt++;
      if (sys3 !== 1'b0) $display("FAIL rst_mid_no_sys%0d: got %b want 0", i, sys3);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_v   = 6'b100100;
    logic [5:0] exp_s   = 6'b100100;
    logic [5:0] exp_sys = 6'b010010;
    logic [5:0] exp_wf  = 6'b101101;
    int markers = 0;
    RESET = 1; idle_inputs();
    step();
    RESET = 0;
    in_valid = 1; in_serial = 1; in_notify = 1; in_payload = P_S;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s1 === 1'b1) markers++;
      tot_cnt++;
      if ({v1, s1, sys1, wf1} !== {exp_v[5-i], exp_s[5-i], exp_sys[5-i], exp_wf[5-i]})
        $display("FAIL b2b_cyc%0d: got v/s/sys/wf=%b want %b", i, {v1, s1, sys1, wf1}, {exp_v[5-i], exp_s[5-i], exp_sys[5-i], exp_wf[5-i]});
      else pass_cnt++;
    end
    tot_cnt++;
    if (markers !== 2) $display("FAIL b2b_markers: got %0d want 2", markers);
    else pass_cnt++;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_syscall(1'b1, "syscall");
    test_syscall(1'b0, "llsc");
    test_miss();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/id_serialize_stage.md
# id_serialize_stage

Parametrised decode-to-execute issue register with serialization control. It is the successor to the fixed syscall bubble counter in the decode stage. It sits between the decoder/operand-read logic and EXE. It registers one decoded instruction bundle per cycle and holds everything while the instruction cache misses. It registers branch/jump redirects for fetch. For serializing instructions (syscall, LL/SC) it drains a programmable number of bubbles, then optionally pulses SYS to the simulator.

## Interface
Parameters:
- DATA_W, 160, width of the opaque decoded bundle (instr, PC, operands, control).
- DRAIN_DEPTH, 3, number of bubble cycles after the serial marker and before the notify cycle; legal range 1..15.
- CNT_W, 4, drain counter width; must hold DRAIN_DEPTH.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- hit  in  1  fetch/I-cache hit; when 0 every register holds.
- in_valid  in  1  a decoded instruction is present.
- in_serial  in  1  the instruction is serializing.
- in_notify  in  1  the serializing instruction needs a SYS pulse (0 for LL/SC).
- in_payload  in  DATA_W  decoded bundle.
- in_redirect  in  1  the instruction requests an alternate PC.
- in_redirect_pc  in  32  alternate PC.
- out_valid  out  1  the bundle in out_payload is real.
- out_serial  out  1  the issued slot is a serial marker; MEM flushes its cache on it.
- out_payload  out  DATA_W  registered bundle; zero on bubbles.
- Alt_PC  out  32  registered redirect target.
- Request_Alt_PC  out  1  registered redirect request.
- SYS  out  1  simulator system-call request.
- WANT_FREEZE  out  1  combinational; fetch must not advance.

## Operation
- Reset value of every output is 0; the FSM is in IDLE; the counter is 0. Reset mid-drain abandons the sequence with no SYS pulse.
- FSM states: IDLE, DRAIN, NOTIFY. Transitions happen only on edges where hit=1.
- IDLE, in_valid=1, in_serial=0:
  - out_valid<=1, out_serial<=0, out_payload<=in_payload.
  - Request_Alt_PC<=in_redirect, Alt_PC<=in_redirect_pc.
- IDLE, in_valid=0: out_valid<=0, out_payload<=0, Request_Alt_PC<=0.
- IDLE, in_valid=1, in_serial=1:
  - out_valid<=1, out_serial<=1, out_payload<=0.
  - Request_Alt_PC<=0; in_redirect is ignored.
  - cnt<=DRAIN_DEPTH, notify flag<=in_notify, next state DRAIN.
- DRAIN:
  - Bubble each cycle: out_valid<=0, out_serial<=0, out_payload<=0, Request_Alt_PC<=0.
  - cnt<=cnt-1.
  - When cnt==1, next state NOTIFY and SYS<=notify flag.
- NOTIFY:
  - Bubble; SYS<=0; next state IDLE.
  - The input is ignored; fetch advances past the serial instruction at the end of this cycle.
- WANT_FREEZE = !hit | (in_valid & in_serial & state!=NOTIFY).
- Back-to-back serial instructions: the second is seen in IDLE after NOTIFY and starts a new sequence. No extra gap is required.

## Timing
- Issue latency is 1 cycle, in_* to out_*. Throughput is 1/cycle in IDLE.
- Serial sequence, measured in hit cycles from the marker edge:
  - marker issued;
  - DRAIN_DEPTH bubbles;
  - SYS high for exactly one hit cycle, during the NOTIFY state;
  - the next instruction is issued at the first edge after NOTIFY.
  - Total occupancy is DRAIN_DEPTH+2 cycles.
- hit=0 at any point:
  - outputs, counter, state and SYS all hold; a SYS pulse is stretched across the miss;
  - WANT_FREEZE=1.
- Alt_PC/Request_Alt_PC update only when hit=1. They hold the last value otherwise.

## Structure
- Shared package id_pkg:
  - state enum ID_SER_IDLE/ID_SER_DRAIN/ID_SER_NOTIFY;
  - the default DRAIN_DEPTH constant;
  - the bundle field offsets used by decode and EXE.
- One sub-module, id_drain_counter: loadable down-counter with a terminal-at-1 flag and a hold enable driven by hit.

## Test plan
- Plain stream, hit=1: three non-serial bundles A,B,C, with B redirecting to 0x400 -> out_payload A,B,C one cycle later, out_valid=1 throughout, Request_Alt_PC=1 and Alt_PC=0x400 only in the cycle after B.
- Syscall, DRAIN_DEPTH=3, in_notify=1 -> 1 marker cycle (out_serial=1), 3 bubbles, SYS=1 for 1 cycle, WANT_FREEZE=1 until NOTIFY, next bundle issued at cycle 6.
- LL with in_notify=0 -> same marker/bubble sequence, SYS stays 0.
- hit=0 for 4 cycles in mid-DRAIN with cnt=2, and a separate hit=0 during NOTIFY -> state and cnt frozen, WANT_FREEZE=1, SYS held high for 5 cycles across the miss, sequence resumes unchanged.
- RESET=1 for 1 cycle while in DRAIN -> all outputs 0 next cycle, state IDLE, no SYS pulse ever produced.
- Two syscalls back-to-back, DRAIN_DEPTH=1 -> two complete marker/bubble/SYS sequences, 3 cycles each, no lost or duplicated marker.
